// File: rtl/bip_program_loader.sv
// Packs received byte pairs (low byte first) into 16-bit BIP instructions and writes them to program memory from address 0.
// A write strobe follows the high byte by one cycle; there is no backpressure, and a byte arriving during a write cycle is kept.
module bip_program_loader #(
    parameter int              NB_DATA            = 16,
    parameter int              NB_BYTE            = 8,
    parameter int              N_ADDR             = 2048,
    parameter int              LOG2_N_INSMEM_ADDR = 11,
    parameter int              NB_OPCODE          = 5,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE   = 5'b00000
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [NB_BYTE-1:0]            i_rx_data,
    input  logic                          i_rx_valid,
    output logic                          o_wr_enable,
    output logic [LOG2_N_INSMEM_ADDR-1:0] o_wr_addr,
    output logic [NB_DATA-1:0]            o_wr_data,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOW   = 3'd1,
        HIGH  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [LOG2_N_INSMEM_ADDR-1:0] LAST_ADDR = LOG2_N_INSMEM_ADDR'(N_ADDR - 1);

    state_t                          r_state, w_next_state;
    logic [LOG2_N_INSMEM_ADDR-1:0]   r_addr, w_next_addr;
    logic [NB_BYTE-1:0]              r_low, w_next_low;
    logic                            r_wr_enable, w_next_wr_enable;
    logic [LOG2_N_INSMEM_ADDR-1:0]   r_wr_addr, w_next_wr_addr;
    logic [NB_DATA-1:0]              r_wr_data, w_next_wr_data;
    logic                            r_busy, r_done, r_error;
    logic                            w_is_halt;

    assign w_is_halt = (r_wr_data[NB_DATA-1 -: NB_OPCODE] == HALT_OPCODE);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_low       <= '0;
            r_wr_enable <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_addr      <= w_next_addr;
            r_low       <= w_next_low;
            r_wr_enable <= w_next_wr_enable;
            r_wr_addr   <= w_next_wr_addr;
            r_wr_data   <= w_next_wr_data;
            // Status flags are decoded from the next state so they change on the same edge as the state.
            r_busy      <= (w_next_state == LOW) || (w_next_state == HIGH) || (w_next_state == WRITE);
            r_done      <= (w_next_state == DONE);
            r_error     <= (w_next_state == ERROR);
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_addr      = r_addr;
        w_next_low       = r_low;
        w_next_wr_enable = 1'b0;
        w_next_wr_addr   = r_wr_addr;
        w_next_wr_data   = r_wr_data;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (i_start) begin
                    w_next_state = LOW;
                    w_next_addr  = '0;
                end
            end
            LOW: begin
                if (i_rx_valid) begin
                    w_next_low   = i_rx_data;
                    w_next_state = HIGH;
                end
            end
            HIGH: begin
                if (i_rx_valid) begin
                    w_next_wr_data   = {i_rx_data, r_low};
                    w_next_wr_addr   = r_addr;
                    w_next_wr_enable = 1'b1;
                    w_next_state     = WRITE;
                end
            end
            WRITE: begin
                if (w_is_halt) begin
                    w_next_state = DONE;
                end else if (r_addr == LAST_ADDR) begin
                    w_next_state = ERROR;
                end else begin
                    w_next_addr = r_addr + 1'b1;
                    // A byte landing in the write cycle is the next word's low byte.
                    if (i_rx_valid) begin
                        w_next_low   = i_rx_data;
                        w_next_state = HIGH;
                    end else begin
                        w_next_state = LOW;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign o_wr_enable = r_wr_enable;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;

endmodule

// File: tb/tb_bip_program_loader.sv
// Bench for bip_program_loader: random byte streams scored against a pair-walking model of the load.
module tb_bip_program_loader;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic        o_wr_enable;
    logic [10:0] o_wr_addr;
    logic [15:0] o_wr_data;
    logic        o_busy, o_done, o_error;

    int checks = 0;
    int errors = 0;

    logic [26:0] wq[$];
    logic [26:0] exp_q[$];
    logic [7:0]  tx_q[$];
    bit          exp_done, exp_error;

    bip_program_loader dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_wr_enable(o_wr_enable),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error)
    );

    always #5 i_clock = ~i_clock;

    always @(negedge i_clock) if (o_wr_enable) wq.push_back({o_wr_addr, o_wr_data});

    // Expected memory image: consecutive byte pairs from address 0, stopping after HALT or the last address.
    function automatic void build_model();
        int addr;
        logic [15:0] w;
        addr = 0;
        exp_q.delete();
        exp_done = 1'b0;
        exp_error = 1'b0;
        for (int i = 0; i + 1 < tx_q.size(); i += 2) begin
            w = {tx_q[i+1], tx_q[i]};
            exp_q.push_back({11'(addr), w});
            if (w[15:11] == 5'd0) begin exp_done = 1'b1; break; end
            if (addr == 2047) begin exp_error = 1'b1; break; end
            addr++;
        end
    endfunction

    task automatic cycle();
        @(posedge i_clock);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        tx_q.push_back(w[7:0]);
        tx_q.push_back(w[15:8]);
    endtask

    task automatic push_random_words(input int n);
        for (int i = 0; i < n; i++) push_word({5'($urandom_range(1, 31)), 11'($urandom)});
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        cycle();
        i_start = 1'b0;
    endtask

    task automatic send_queue(input int gap_max, input bit noise);
        for (int i = 0; i < tx_q.size(); i++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = tx_q[i];
            if (noise) i_start = 1'($urandom);
            cycle();
            i_rx_valid = 1'b0;
            i_start    = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) cycle();
        end
    endtask

    task automatic wait_end();
        for (int i = 0; i < 20 && !(o_done || o_error); i++) cycle();
        cycle();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        cycle();
        cycle();
        checks++;
        if ({o_wr_enable, o_wr_addr, o_wr_data, o_busy, o_done, o_error} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {o_wr_enable, o_wr_addr, o_wr_data, o_busy, o_done, o_error});
        end
        i_reset = 1'b0;
        cycle();
    endtask

    task automatic test_prestart();
        wq.delete();
        tx_q.delete();
        repeat (3) tx_q.push_back(8'($urandom));
        send_queue(1, 1'b0);
        cycle();
        checks++;
        if (wq.size() != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL prestart_ignored got writes=%0d busy=%b want 0 0", wq.size(), o_busy);
        end
        pulse_start();
        tx_q.delete();
        push_random_words(3);
        push_word(16'h0000);
        build_model();
        send_queue(2, 1'b0);
        wait_end();
        checks++;
        if (wq.size() != exp_q.size()) begin
            errors++;
            $display("FAIL prestart_count got %0d want %0d", wq.size(), exp_q.size());
        end
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wq[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL prestart_write[%0d] got %h want %h", i, wq[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_basic();
        wq.delete();
        pulse_start();
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got busy=%b done=%b want 1 0", o_busy, o_done);
        end
        tx_q = '{8'h05, 8'h08, 8'h00, 8'h00};
        send_queue(0, 1'b0);
        @(negedge i_clock);
        checks++;
        if (o_wr_enable !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_last_write got we=%b done=%b want 1 0", o_wr_enable, o_done);
        end
        @(negedge i_clock);
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_wr_enable !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got done=%b busy=%b we=%b want 1 0 0", o_done, o_busy, o_wr_enable);
        end
        cycle();
        checks++;
        if (wq.size() != 2 || wq[0] !== {11'd0, 16'h0805} || wq[1] !== {11'd1, 16'h0000}) begin
            errors++;
            $display("FAIL basic_writes got n=%0d %h %h want 2 %h %h", wq.size(),
                     (wq.size() > 0) ? wq[0] : 27'h0, (wq.size() > 1) ? wq[1] : 27'h0,
                     {11'd0, 16'h0805}, {11'd1, 16'h0000});
        end
    endtask

    task automatic test_back_to_back();
        wq.delete();
        pulse_start();
        tx_q.delete();
        push_random_words(2);
        push_word(16'h0123);
        build_model();
        send_queue(0, 1'b0);
        wait_end();
        checks++;
        if (o_done !== exp_done || wq.size() != 3) begin
            errors++;
            $display("FAIL b2b_status got done=%b n=%0d want %b 3", o_done, wq.size(), exp_done);
        end
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wq[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_write[%0d] got %h want %h", i, wq[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        wq.delete();
        pulse_start();
        tx_q.delete();
        repeat (2048) push_word(16'hFFFF);
        build_model();
        send_queue(0, 1'b0);
        wait_end();
        checks++;
        if (o_error !== exp_error || o_done !== exp_done || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL overflow_status got err=%b done=%b busy=%b want %b %b 0", o_error, o_done, o_busy, exp_error, exp_done);
        end
        checks++;
        if (wq.size() != exp_q.size() || wq.size() == 0 || wq[wq.size()-1] !== {11'd2047, 16'hFFFF}) begin
            errors++;
            $display("FAIL overflow_last got n=%0d last=%h want %0d %h", wq.size(),
                     (wq.size() > 0) ? wq[wq.size()-1] : 27'h0, exp_q.size(), {11'd2047, 16'hFFFF});
        end
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wq[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL overflow_write[%0d] got %h want %h", i, wq[i], exp_q[i]);
            end
        end
        wq.delete();
        tx_q.delete();
        repeat (4) tx_q.push_back(8'($urandom));
        send_queue(1, 1'b0);
        cycle();
        checks++;
        if (wq.size() != 0 || o_error !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL overflow_sticky got n=%0d err=%b done=%b want 0 1 0", wq.size(), o_error, o_done);
        end
    endtask

    task automatic test_reset_midload();
        pulse_start();
        checks++;
        if (o_error !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL rearm_from_error got err=%b busy=%b want 0 1", o_error, o_busy);
        end
        tx_q.delete();
        push_random_words(1);
        tx_q.push_back(8'($urandom));
        send_queue(1, 1'b0);
        i_reset = 1'b1;
        cycle();
        i_reset = 1'b0;
        checks++;
        if ({o_wr_enable, o_wr_addr, o_wr_data, o_busy, o_done, o_error} !== 31'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0", {o_wr_enable, o_wr_addr, o_wr_data, o_busy, o_done, o_error});
        end
        wq.delete();
        pulse_start();
        tx_q.delete();
        push_random_words(4);
        push_word({5'd0, 11'($urandom)});
        build_model();
        send_queue(3, 1'b0);
        wait_end();
        checks++;
        if (o_done !== exp_done || wq.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midreset_reload got done=%b n=%0d want %b %0d", o_done, wq.size(), exp_done, exp_q.size());
        end
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wq[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midreset_write[%0d] got %h want %h", i, wq[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_rearm();
        for (int r = 0; r < 3; r++) begin
            wq.delete();
            pulse_start();
            checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL rearm_flags got done=%b busy=%b want 0 1", o_done, o_busy);
            end
            tx_q.delete();
            push_random_words($urandom_range(1, 6));
            push_word({5'd0, 11'($urandom)});
            build_model();
            send_queue(2, 1'b1);
            wait_end();
            checks++;
            if (o_done !== exp_done || wq.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rearm_status got done=%b n=%0d want %b %0d", o_done, wq.size(), exp_done, exp_q.size());
            end
            for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
                checks++;
                if (wq[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rearm_write[%0d] got %h want %h", i, wq[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_prestart();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_reset_midload();
        test_rearm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
